fb_io_1_2_buf: RTL and testbench
================================

// Module: fb_io_1_2_buf
// PURPOSE
//  Output-side IO block: one handshaked input stream is buffered and steered to two outputs.
//  Steering is set by a 2-bit config word loaded through the serial config chain.
//  Sits at the array boundary, fed by an fb_io_2_1 output or a fabric switch.
//  Delivers to two external sinks with valid/ready back-pressure.
// PARAMETERS
//  size   32  data width of in0/out0/out1
//  DEPTH  2   FIFO entries (>=2); counter width CW = $clog2(DEPTH+1)
// PORTS
//  clk         in   1     single clock, all logic posedge
//  reset_n     in   1     asynchronous, active-low reset
//  config_en   in   1     1 = shift config chain this cycle (on clk)
//  config_in   in   1     serial config data in
//  config_out  out  1     serial config data out (= cfg[0])
//  in0         in   size  input data
//  in0_valid   in   1     input word valid
//  in0_ready   out  1     block accepts a word this cycle
//  out0        out  size  output 0 data
//  out0_valid  out  1     output 0 word valid
//  out0_ready  in   1     sink 0 accepts
//  out1        out  size  output 1 data
//  out1_valid  out  1     output 1 word valid
//  out1_ready  in   1     sink 1 accepts
// BEHAVIOUR
//  Interface: one clock clk; reset_n is asynchronous and active-low.
//  Reset values: cfg=2'b00, count=0, rd/wr ptr=0, rr=0, sent=2'b00,
//   out0_valid=out1_valid=0, config_out=0. out0=out1=0 whenever FIFO empty.
//  Config: if config_en, cfg <= {config_in, cfg[1]} each clk. While config_en=1:
//   in0_ready=0, out*_valid=0, rr and sent cleared; FIFO contents kept.
//  Modes (cfg): 00 -> out0 only; 01 -> out1 only; 10 -> broadcast; 11 -> round-robin.
//  FIFO: in0_ready = (count!=DEPTH) & !config_en. Push on in0_valid & in0_ready.
//   Pointers wrap at DEPTH-1 -> 0.
//   When full, no push even if a pop occurs that cycle (no ready-to-ready comb path).
//   Simultaneous push+pop when not full: count unchanged.
//  Latency: word pushed at edge N is first presented on out* in cycle N+1 (no bypass).
//  out0 = out1 = FIFO head data (driven to both, qualified by valid).
//  Mode 00/01: selected out valid = !empty; other valid = 0.
//   Pop on selected valid & ready.
//  Mode 10: outK_valid = !empty & !sent[K]. Accept on K sets sent[K].
//   Pop when each output is sent or accepting this cycle; on pop, sent <= 0.
//   Outputs need not be ready in the same cycle.
//  Mode 11: head offered only to out[rr]. On accept: pop, rr <= ~rr.
//   rr persists across empty periods.
//  Config change mid-stream is legal only with config_en. Buffered words are then
//   delivered per the new mode.
//  Reset asserted mid-transfer: FIFO emptied, valids drop immediately (async).
// TESTING
//  1 Reset, shift cfg=00 (config_in 0,0), push A=0x11,B=0x22
//     -> out0 shows 0x11 then 0x22, out1_valid never 1.
//  2 cfg=00, out0_ready=0, push 3 words -> 3rd stalls (in0_ready=0 after 2).
//     Raise ready -> order preserved, count returns to 0.
//  3 cfg=10, push 0xAB; out1_ready=1 and out0_ready=0 for 3 cycles, then out0_ready=1
//     -> out1 takes 0xAB once (out1_valid then 0), pop only on out0 accept.
//  4 cfg=11, push 0x1,0x2,0x3, both ready -> out0 gets 0x1, out1 0x2, out0 0x3;
//     rr resumes at out1 for next word.
//  5 Push with both ready and full FIFO -> no push that cycle; count goes DEPTH -> DEPTH-1.
//  6 Assert reset_n=0 with 2 words buffered
//     -> valids and out data 0 same cycle, in0_ready=1 after release, cfg=00.

Source files
------------

// File: rtl/fb_io_1_2_buf.sv
// fb_io_1_2_buf: output-side IO block. One valid/ready input stream is buffered
// in a small FIFO and steered to out0, out1, both (broadcast) or alternately
// (round-robin), selected by a 2-bit word loaded through the serial config chain.
module fb_io_1_2_buf #(
  parameter int unsigned size  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            config_en,
  input  logic            config_in,
  output logic            config_out,
  input  logic [size-1:0] in0,
  input  logic            in0_valid,
  output logic            in0_ready,
  output logic [size-1:0] out0,
  output logic            out0_valid,
  input  logic            out0_ready,
  output logic [size-1:0] out1,
  output logic            out1_valid,
  input  logic            out1_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_OUT0 = 2'b00;
  localparam logic [1:0] MODE_OUT1 = 2'b01;
  localparam logic [1:0] MODE_BCAST = 2'b10;

  logic [1:0]    cfg_q, cfg_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          rr_q, rr_d;
  logic [1:0]    sent_q, sent_d;
  logic [size-1:0] mem_q [DEPTH];

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            acc0;
  logic            acc1;
  logic [size-1:0] head;

  // FIFO status, input handshake and head data (zero while empty)
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    in0_ready = !full && !config_en;
    push      = in0_valid && in0_ready;
    head      = empty ? '0 : mem_q[rd_ptr_q];
    out0      = head;
    out1      = head;
  end

  // Steering per mode: output valids, pop decision, broadcast/round-robin tracking, config shift
  always_comb begin
    out0_valid = 1'b0;
    out1_valid = 1'b0;
    acc0       = 1'b0;
    acc1       = 1'b0;
    pop        = 1'b0;
    sent_d     = sent_q;
    rr_d       = rr_q;
    cfg_d      = cfg_q;
    if (config_en) begin
      cfg_d  = {config_in, cfg_q[1]};
      sent_d = 2'b00;
      rr_d   = 1'b0;
    end else begin
      case (cfg_q)
        MODE_OUT0: begin
          out0_valid = !empty;
          pop        = out0_valid && out0_ready;
        end
        MODE_OUT1: begin
          out1_valid = !empty;
          pop        = out1_valid && out1_ready;
        end
        MODE_BCAST: begin
          out0_valid = !empty && !sent_q[0];
          out1_valid = !empty && !sent_q[1];
          acc0       = out0_valid && out0_ready;
          acc1       = out1_valid && out1_ready;
          pop        = !empty && (sent_q[0] || acc0) && (sent_q[1] || acc1);
          sent_d     = pop ? 2'b00 : (sent_q | {acc1, acc0});
        end
        default: begin
          out0_valid = !empty && !rr_q;
          out1_valid = !empty && rr_q;
          pop        = (out0_valid && out0_ready) || (out1_valid && out1_ready);
          if (pop) rr_d = ~rr_q;
        end
      endcase
    end
  end

  // Pointer wrap and occupancy update
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q    <= 2'b00;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rr_q     <= 1'b0;
      sent_q   <= 2'b00;
    end else begin
      cfg_q    <= cfg_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rr_q     <= rr_d;
      sent_q   <= sent_d;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in0;
  end

  assign config_out = cfg_q[0];

endmodule

// File: tb/tb_fb_io_1_2_buf.sv
// Directed testbench for fb_io_1_2_buf: one task per scenario, inline checks.
module tb_fb_io_1_2_buf;

  logic        clk;
  logic        reset_n;
  logic        config_en;
  logic        config_in;
  logic        config_out;
  logic [31:0] in0;
  logic        in0_valid;
  logic        in0_ready;
  logic [31:0] out0;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out1;
  logic        out1_valid;
  logic        out1_ready;

  int errors = 0;
  int checks = 0;

  fb_io_1_2_buf #(.size(32), .DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .config_en  (config_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in0        (in0),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .out0       (out0),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1       (out1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cfg ends up as {b1, b0}
  task automatic shift_cfg(input logic b0, input logic b1);
    config_en = 1'b1;
    config_in = b0;
    tick();
    config_in = b1;
    tick();
    config_en = 1'b0;
    config_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL rst_v0: got %b want 0", out0_valid); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_v1: got %b want 0", out1_valid); end
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL rst_cfgout: got %b want 0", config_out); end
    checks++; if (out0 !== 32'h0) begin errors++; $display("FAIL rst_out0: got %h want 0", out0); end
    checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in0_ready); end
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_mode00();
    shift_cfg(1'b0, 1'b0);
    out0_ready = 1'b0; out1_ready = 1'b1;
    in0 = 32'h11; in0_valid = 1'b1;
    #1;
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL m00_nobypass: got %b want 0", out0_valid); end
    tick();
    checks++; if (out0_valid !== 1'b1 || out0 !== 32'h11) begin errors++; $display("FAIL m00_first: got v=%b d=%h want v=1 d=11", out0_valid, out0); end
    in0 = 32'h22;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL m00_full: got %b want 0", in0_ready); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL m00_v1a: got %b want 0", out1_valid); end
    out0_ready = 1'b1;
    #1;
    checks++; if (out0 !== 32'h11) begin errors++; $display("FAIL m00_head1: got %h want 11", out0); end
    tick();
    checks++; if (out0_valid !== 1'b1 || out0 !== 32'h22) begin errors++; $display("FAIL m00_head2: got v=%b d=%h want v=1 d=22", out0_valid, out0); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL m00_v1b: got %b want 0", out1_valid); end
    tick();
    checks++; if (out0_valid !== 1'b0 || out0 !== 32'h0) begin errors++; $display("FAIL m00_empty: got v=%b d=%h want v=0 d=0", out0_valid, out0); end
  endtask

  task automatic test_stall();
    out0_ready = 1'b0;
    in0 = 32'h31; in0_valid = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy1: got %b want 1", in0_ready); end
    tick();
    in0 = 32'h32;
    #1;
    checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL stall_rdy2: got %b want 1", in0_ready); end
    tick();
    in0 = 32'h33;
    #1;
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy3: got %b want 0", in0_ready); end
    tick();
    checks++; if (in0_ready !== 1'b0 || out0 !== 32'h31) begin errors++; $display("FAIL stall_hold: got r=%b d=%h want r=0 d=31", in0_ready, out0); end
    out0_ready = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL stall_nopass: got %b want 0", in0_ready); end
    tick();
    checks++; if (out0 !== 32'h32 || in0_ready !== 1'b1) begin errors++; $display("FAIL stall_pop1: got d=%h r=%b want d=32 r=1", out0, in0_ready); end
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out0 !== 32'h33 || out0_valid !== 1'b1) begin errors++; $display("FAIL stall_pop2: got d=%h v=%b want d=33 v=1", out0, out0_valid); end
    tick();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", out0_valid); end
  endtask

  task automatic test_broadcast();
    config_en = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL cfg_blocks_in: got %b want 0", in0_ready); end
    shift_cfg(1'b0, 1'b1);
    out0_ready = 1'b0; out1_ready = 1'b1;
    in0 = 32'hAB; in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || out1 !== 32'hAB) begin errors++; $display("FAIL bc_offer: got v0=%b v1=%b d=%h want 1 1 ab", out0_valid, out1_valid, out1); end
    tick();
    checks++; if (out1_valid !== 1'b0 || out0_valid !== 1'b1) begin errors++; $display("FAIL bc_sent1: got v0=%b v1=%b want 1 0", out0_valid, out1_valid); end
    tick();
    tick();
    checks++; if (out1_valid !== 1'b0 || out0_valid !== 1'b1 || out0 !== 32'hAB) begin errors++; $display("FAIL bc_hold: got v0=%b v1=%b d=%h want 1 0 ab", out0_valid, out1_valid, out0); end
    out0_ready = 1'b1;
    tick();
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL bc_pop: got v0=%b v1=%b want 0 0", out0_valid, out1_valid); end
  endtask

  task automatic test_round_robin();
    shift_cfg(1'b1, 1'b1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    in0 = 32'h1; in0_valid = 1'b1;
    tick();
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0 !== 32'h1) begin errors++; $display("FAIL rr_w1: got v0=%b v1=%b d=%h want 1 0 1", out0_valid, out1_valid, out0); end
    in0 = 32'h2;
    tick();
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1 !== 32'h2) begin errors++; $display("FAIL rr_w2: got v0=%b v1=%b d=%h want 0 1 2", out0_valid, out1_valid, out1); end
    in0 = 32'h3;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0 !== 32'h3) begin errors++; $display("FAIL rr_w3: got v0=%b v1=%b d=%h want 1 0 3", out0_valid, out1_valid, out0); end
    tick();
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL rr_empty: got v0=%b v1=%b want 0 0", out0_valid, out1_valid); end
    tick();
    in0 = 32'h4; in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1 !== 32'h4) begin errors++; $display("FAIL rr_resume: got v0=%b v1=%b d=%h want 0 1 4", out0_valid, out1_valid, out1); end
    tick();
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", out1_valid); end
  endtask

  task automatic test_full_push();
    shift_cfg(1'b0, 1'b0);
    out0_ready = 1'b0; out1_ready = 1'b1;
    in0 = 32'h51; in0_valid = 1'b1;
    tick();
    in0 = 32'h52;
    tick();
    in0 = 32'h53;
    out0_ready = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL full_rdy: got %b want 0", in0_ready); end
    tick();
    checks++; if (out0 !== 32'h52 || in0_ready !== 1'b1) begin errors++; $display("FAIL full_nopush: got d=%h r=%b want d=52 r=1", out0, in0_ready); end
    in0_valid = 1'b0;
    tick();
    checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL full_count: got v=%b want 0", out0_valid); end
  endtask

  task automatic test_async_reset();
    shift_cfg(1'b1, 1'b0);
    out0_ready = 1'b0; out1_ready = 1'b0;
    in0 = 32'h61; in0_valid = 1'b1;
    tick();
    in0 = 32'h62;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out1_valid !== 1'b1 || out0_valid !== 1'b0 || config_out !== 1'b1) begin errors++; $display("FAIL ar_pre: got v0=%b v1=%b co=%b want 0 1 1", out0_valid, out1_valid, config_out); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL ar_valids: got v0=%b v1=%b want 0 0", out0_valid, out1_valid); end
    checks++; if (out0 !== 32'h0 || out1 !== 32'h0) begin errors++; $display("FAIL ar_data: got %h %h want 0 0", out0, out1); end
    checks++; if (config_out !== 1'b0) begin errors++; $display("FAIL ar_cfgout: got %b want 0", config_out); end
    tick();
    reset_n = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", in0_ready); end
    in0 = 32'h71; in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    #1;
    checks++; if (out0_valid !== 1'b1 || out1_valid !== 1'b0 || out0 !== 32'h71) begin errors++; $display("FAIL ar_cfg00: got v0=%b v1=%b d=%h want 1 0 71", out0_valid, out1_valid, out0); end
  endtask

  initial begin
    reset_n    = 1'b0;
    config_en  = 1'b0;
    config_in  = 1'b0;
    in0        = '0;
    in0_valid  = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    test_reset();
    test_mode00();
    test_stall();
    test_broadcast();
    test_round_robin();
    test_full_push();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
